// File: rtl/regfile_dump.sv
// Register-file dump sequencer: reads NUM_REGS registers through a debug port and streams (idx, data) records.
// Optional running-XOR checksum output enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rf_rd_en,
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [2:0]       LAT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] rd_sel;
  logic              handshake;

  // $0 is hard-wired zero; the read is still issued so record timing stays uniform.
  always_comb begin
    rd_sel = rf_rd_data;
    if (idx == '0) rd_sel = '0;
  end

  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      lat_cnt  <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            idx   <= '0;
          end
        end
        S_READ: begin
          if (RD_LAT == 0) begin
            out_data <= rd_sel;
            state    <= S_PRESENT;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            out_data <= rd_sel;
            state    <= S_PRESENT;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          idx   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rf_rd_en   = (state == S_READ);
  assign rf_rd_addr = idx;
  assign out_valid  = (state == S_PRESENT);
  assign out_idx    = idx;
  assign out_last   = (state == S_PRESENT) && (idx == LAST_IDX);
  assign busy       = (state == S_READ) || (state == S_WAIT) || (state == S_PRESENT);
  assign done       = (state == S_DONE);

`ifdef REGDUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == S_IDLE && start) begin
      csum <= '0;
    end else if (handshake) begin
      csum <= csum ^ out_data;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = handshake;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: three instances (RD_LAT 1, 0, 3) share one register-file image.
// Expected records are queued at start; a negedge monitor pops and compares on every handshake.
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  localparam logic [31:0] BAD = 32'hBADB_AD00;

  logic        start0, start1, start2;
  logic        ready0, ready1, ready2;
  logic        rd_en0, rd_en1, rd_en2;
  logic [4:0]  rd_addr0, rd_addr1, rd_addr2;
  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        valid0, valid1, valid2;
  logic [4:0]  idx0, idx1, idx2;
  logic [31:0] data0, data1, data2;
  logic        last0, last1, last2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] csum0, csum1, csum2;
`endif

  regfile_dump #(.NUM_REGS(32), .DATA_W(32), .IDX_W(5), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rf_rd_en(rd_en0), .rf_rd_addr(rd_addr0),
    .rf_rd_data(rd_data0), .out_valid(valid0), .out_ready(ready0), .out_idx(idx0),
    .out_data(data0), .out_last(last0), .busy(busy0), .done(done0)
`ifdef REGDUMP_CHECKSUM_EN
    , .csum(csum0)
`endif
  );

  regfile_dump #(.NUM_REGS(32), .DATA_W(32), .IDX_W(5), .RD_LAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rf_rd_en(rd_en1), .rf_rd_addr(rd_addr1),
    .rf_rd_data(rd_data1), .out_valid(valid1), .out_ready(ready1), .out_idx(idx1),
    .out_data(data1), .out_last(last1), .busy(busy1), .done(done1)
`ifdef REGDUMP_CHECKSUM_EN
    , .csum(csum1)
`endif
  );

  regfile_dump #(.NUM_REGS(32), .DATA_W(32), .IDX_W(5), .RD_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rf_rd_en(rd_en2), .rf_rd_addr(rd_addr2),
    .rf_rd_data(rd_data2), .out_valid(valid2), .out_ready(ready2), .out_idx(idx2),
    .out_data(data2), .out_last(last2), .busy(busy2), .done(done2)
`ifdef REGDUMP_CHECKSUM_EN
    , .csum(csum2)
`endif
  );

  // Register-file models: data is only meaningful exactly RD_LAT cycles after the enable.
  logic        p0v = 1'b0;
  logic [31:0] p0d;
  logic [2:0]  p2v = 3'b000;
  logic [31:0] p2d [3];
  always @(posedge clk) begin
    p0v    <= rd_en0;
    p0d    <= mem[rd_addr0];
    p2v    <= {p2v[1:0], rd_en2};
    p2d[0] <= mem[rd_addr2];
    p2d[1] <= p2d[0];
    p2d[2] <= p2d[1];
  end
  assign rd_data0 = p0v ? p0d : BAD;
  assign rd_data1 = rd_en1 ? mem[rd_addr1] : BAD;
  assign rd_data2 = p2v[2] ? p2d[2] : BAD;

  logic [37:0] q0[$];
  logic [37:0] q1[$];
  logic [37:0] q2[$];
  int  done_cnt [3] = '{0, 0, 0};
  int  last_hs [3]  = '{-10, -10, -10};
  int  first_cyc [3];
  int  start_cyc [3];
  bit  seen [3]     = '{1'b1, 1'b1, 1'b1};
  bit  track_busy   = 1'b0;
  int  busy_gaps    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [37:0] qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push_dump(input int i);
    logic [37:0] rec;
    for (int r = 0; r < 32; r++) begin
      rec = {(r == 31), 5'(r), (r == 0) ? 32'h0 : mem[r]};
      case (i)
        0: q0.push_back(rec);
        1: q1.push_back(rec);
        default: q2.push_back(rec);
      endcase
    end
  endtask

  task automatic observe(input int i, input logic v, input logic r, input logic [4:0] idx,
                         input logic [31:0] d, input logic last, input logic dn, input logic bz);
    logic [37:0] exp;
    if (v && !seen[i]) begin
      seen[i]      = 1'b1;
      first_cyc[i] = cyc;
    end
    if (v && r) begin
      if (qsize(i) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record inst%0d: got idx %0d data %h expected none", i, idx, d);
      end else begin
        exp = qpop(i);
        check($sformatf("record inst%0d", i), {26'h0, last, idx, d}, {26'h0, exp});
      end
      if (last) last_hs[i] = cyc;
    end
    if (dn) begin
      done_cnt[i]++;
      check($sformatf("done_timing inst%0d", i), 64'(cyc), 64'(last_hs[i] + 1));
      check($sformatf("busy_in_done inst%0d", i), {63'h0, bz}, 64'h0);
    end
  endtask

  always @(negedge clk) begin
    observe(0, valid0, ready0, idx0, data0, last0, done0, busy0);
    observe(1, valid1, ready1, idx1, data1, last1, done1, busy1);
    observe(2, valid2, ready2, idx2, data2, last2, done2, busy2);
    if (track_busy && !busy0 && !done0) busy_gaps++;
  end

  task automatic set_start(input int i, input logic v);
    case (i)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic do_start(input int i);
    push_dump(i);
    seen[i]      = 1'b0;
    start_cyc[i] = cyc;
    set_start(i, 1'b1);
    @(posedge clk); #1;
    set_start(i, 1'b0);
  endtask

  task automatic wait_done(input int i, input int prev);
    int n = 0;
    while (done_cnt[i] == prev && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt[i] == prev) begin
      checks++;
      errors++;
      $display("FAIL done_timeout inst%0d: got no done pulse expected one", i);
    end
  endtask

  task automatic wait_rec0(input logic [4:0] want);
    int n = 0;
    while (!(valid0 && idx0 == want) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("reach_record_%0d", want), {63'h0, valid0 && idx0 == want}, 64'h1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_en"},   {63'h0, rd_en0},  64'h0);
    check({tag, "_rd_addr"}, {59'h0, rd_addr0}, 64'h0);
    check({tag, "_valid"},   {63'h0, valid0},  64'h0);
    check({tag, "_idx"},     {59'h0, idx0},    64'h0);
    check({tag, "_data"},    {32'h0, data0},   64'h0);
    check({tag, "_last"},    {63'h0, last0},   64'h0);
    check({tag, "_busy"},    {63'h0, busy0},   64'h0);
    check({tag, "_done"},    {63'h0, done0},   64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'hFFFF_0000;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic dump, RD_LAT=1
    prev = done_cnt[0];
    do_start(0);
    wait_done(0, prev);
    check("latency_lat1", 64'(first_cyc[0] - start_cyc[0]), 64'd3);
    repeat (5) @(posedge clk);
    #1;
    check("done_once_basic", 64'(done_cnt[0]), 64'(prev + 1));
    check("queue_empty_basic", 64'(q0.size()), 64'd0);

    // Backpressure on record 7, then an ignored start during record 10
    mem[7] = 32'hDEAD_BEEF;
    prev = done_cnt[0];
    do_start(0);
    track_busy = 1'b1;
    wait_rec0(5'd7);
    ready0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'h0, valid0}, 64'h1);
      check("hold_idx",   {59'h0, idx0},   64'd7);
      check("hold_data",  {32'h0, data0},  64'hDEAD_BEEF);
    end
    ready0 = 1'b1;
    wait_rec0(5'd10);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done(0, prev);
    track_busy = 1'b0;
    check("busy_no_gap", 64'(busy_gaps), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("done_once_ignored_start", 64'(done_cnt[0]), 64'(prev + 1));
    check("queue_empty_bp", 64'(q0.size()), 64'd0);
    check("idle_after_ignored_start", {63'h0, busy0}, 64'h0);
    mem[7] = 32'h1000_0007;

    // Reset while waiting on the read of index 15
    prev = done_cnt[0];
    do_start(0);
    begin
      int n = 0;
      while (!(rd_en0 && rd_addr0 == 5'd15) && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      check("reach_read_15", {63'h0, rd_en0 && rd_addr0 == 5'd15}, 64'h1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    q0.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("no_done_on_reset", 64'(done_cnt[0]), 64'(prev));
    @(posedge clk); #1;
    do_start(0);
    wait_done(0, prev);
    check("latency_after_reset", 64'(first_cyc[0] - start_cyc[0]), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty_after_reset", 64'(q0.size()), 64'd0);

    // Latency sweep
    prev = done_cnt[1];
    do_start(1);
    wait_done(1, prev);
    check("latency_lat0", 64'(first_cyc[1] - start_cyc[1]), 64'd2);
    prev = done_cnt[2];
    do_start(2);
    wait_done(2, prev);
    check("latency_lat3", 64'(first_cyc[2] - start_cyc[2]), 64'd5);
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty_lat0", 64'(q1.size()), 64'd0);
    check("queue_empty_lat3", 64'(q2.size()), 64'd0);

`ifdef REGDUMP_CHECKSUM_EN
    for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
    prev = done_cnt[0];
    do_start(0);
    check("csum_cleared_on_start", {32'h0, csum0}, 64'h0);
    wait_done(0, prev);
    check("csum_final", {32'h0, csum0}, 64'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #1;
    check("csum_hold", {32'h0, csum0}, 64'hFFFF_FFFF);
    prev = done_cnt[0];
    do_start(0);
    check("csum_cleared_restart", {32'h0, csum0}, 64'h0);
    wait_done(0, prev);
    check("csum_final_2", {32'h0, csum0}, 64'hFFFF_FFFF);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
